// File: rtl/noc_pkg.sv
// Shared definitions for the mesh NoC traffic endpoints (generator and collector).
// Holds the single-flit packet layout, the ID widths derived from the mesh
// dimension, the generator FSM state encoding and a helper that assembles a flit.
package noc_pkg;

  localparam int DATA_W = 32;
  localparam int DIM    = 4;
  localparam int ID_W   = (DIM - 1) * 2;
  localparam int TS_W   = 10;
  localparam int PID_W  = 10;

  // Flit field positions, MSB to LSB: timestamp, destination, packet ID, source.
  localparam int TS_MSB  = 31;
  localparam int TS_LSB  = 22;
  localparam int DST_MSB = 21;
  localparam int DST_LSB = 16;
  localparam int PID_MSB = 15;
  localparam int PID_LSB = 6;
  localparam int SRC_MSB = 5;
  localparam int SRC_LSB = 0;

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_REQ  = 2'd1,
    GEN_GAP  = 2'd2
  } gen_state_e;

  // Assemble one flit from its fields; bits outside the fields stay zero.
  function automatic logic [DATA_W-1:0] packFlit(
    input logic [TS_W-1:0]  ts,
    input logic [ID_W-1:0]  dst,
    input logic [PID_W-1:0] pid,
    input logic [ID_W-1:0]  src
  );
    logic [DATA_W-1:0] flit;
    flit                   = '0;
    flit[TS_MSB:TS_LSB]    = ts;
    flit[DST_MSB:DST_LSB]  = dst;
    flit[PID_MSB:PID_LSB]  = pid;
    flit[SRC_MSB:SRC_LSB]  = src;
    return flit;
  endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as a cheap pseudo-random source
// by NoC traffic generators.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset, loads Seed
//   en_i     advance one step per clock when high
//   state_o  current 16-bit register contents
module noc_lfsr16 #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        feedback;

  // Right-shifting form: tap n of the polynomial sits at bit (16 - n).
  always_comb begin
    feedback = state_q[0] ^ state_q[2] ^ state_q[3] ^ state_q[5];
    state_d  = en_i ? {feedback, state_q[15:1]} : state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/packet_generator_local.sv
// Traffic source for one router's Local input port. Builds single-flit packets
// and pushes them into the router with a Req/Gnt handshake, throttled by an
// LFSR-driven injection gate and an optional packet budget.
// Ports:
//   clk        clock
//   reset      asynchronous active-low reset
//   Enable     allow new packets to start
//   PacketOut  flit presented to the router (held while ReqDnStr is high)
//   ReqDnStr   request to the router
//   GntDnStr   grant from the router
//   DnStrFull  router Local input buffer full (only blocks new starts)
//   Done       packet budget exhausted, sticky until reset
//   SentCount  number of granted packets
module packet_generator_local
  import noc_pkg::*;
#(
  parameter logic [5:0]  routerID   = 6'b000_000,
  parameter int          dataWidth  = 32,
  parameter int          dim        = 4,
  parameter logic [5:0]  DestID     = 6'b000_001,
  parameter bit          RandDest   = 1'b0,
  parameter logic [7:0]  InjRate    = 8'd255,
  parameter int          MaxPackets = 100,
  parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Enable,
  output logic [dataWidth-1:0] PacketOut,
  output logic                 ReqDnStr,
  input  logic                 GntDnStr,
  input  logic                 DnStrFull,
  output logic                 Done,
  output logic [31:0]          SentCount
);

  localparam int         IdW     = (dim - 1) * 2;
  localparam logic [31:0] MaxPkts = 32'(MaxPackets);

  gen_state_e           state_q;
  logic [dataWidth-1:0] packet_q;
  logic                 req_q;
  logic                 done_q;
  logic [31:0]          sentCnt_q;
  logic [PID_W-1:0]     pktId_q;
  logic [31:0]          cycleCnt_q;

  logic [15:0]          lfsr;
  logic [dataWidth-1:0] flit_d;
  logic [IdW-1:0]       destSel;
  logic                 gateOpen;
  logic                 startPkt;
  logic                 budgetHit;
  logic                 unusedBits;

  noc_lfsr16 #(
    .Seed(LfsrSeed)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .state_o(lfsr)
  );

  // Injection gate, destination choice and the flit that would be launched
  // this cycle. A random destination equal to our own node is bumped by one
  // so the generator never addresses itself.
  always_comb begin
    gateOpen = (lfsr[7:0] < InjRate) || (InjRate == 8'd255);
    destSel  = DestID[IdW-1:0];
    if (RandDest) begin
      destSel = lfsr[8 +: IdW];
      if (lfsr[8 +: IdW] == routerID[IdW-1:0]) begin
        destSel = routerID[IdW-1:0] + IdW'(1);
      end
    end
    flit_d    = packFlit(cycleCnt_q[TS_W-1:0], destSel, pktId_q, routerID[IdW-1:0]);
    startPkt  = Enable && !done_q && !DnStrFull && gateOpen;
    budgetHit = (MaxPackets != 0) && ((sentCnt_q + 32'd1) == MaxPkts);
  end

  // Only the low timestamp bits and the low 14 LFSR bits feed any field.
  assign unusedBits = ^{lfsr[15:14], cycleCnt_q[31:TS_W]};

  // Injection FSM with registered outputs. While in REQ the flit and request
  // are frozen regardless of DnStrFull or Enable; GAP inserts one dead cycle
  // so requests are at least two cycles apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= GEN_IDLE;
      packet_q   <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      sentCnt_q  <= '0;
      pktId_q    <= '0;
      cycleCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_q + 32'd1;
      case (state_q)
        GEN_IDLE: begin
          req_q <= 1'b0;
          if (startPkt) begin
            packet_q <= flit_d;
            req_q    <= 1'b1;
            state_q  <= GEN_REQ;
          end
        end
        GEN_REQ: begin
          if (GntDnStr) begin
            req_q     <= 1'b0;
            pktId_q   <= pktId_q + PID_W'(1);
            sentCnt_q <= sentCnt_q + 32'd1;
            if (budgetHit) begin
              done_q <= 1'b1;
            end
            state_q   <= GEN_GAP;
          end
        end
        GEN_GAP: begin
          state_q <= GEN_IDLE;
        end
        default: begin
          state_q <= GEN_IDLE;
        end
      endcase
    end
  end

  assign PacketOut = packet_q;
  assign ReqDnStr  = req_q;
  assign Done      = done_q;
  assign SentCount = sentCnt_q;

endmodule
